wb_pipe: RTL and testbench
==========================

# wb_pipe

Parametrised, pipelined writeback stage for the RISC-V core. It replaces the single-cycle combinational writeback mux for configurations where data memory has a multi-cycle fixed read latency. Each accepted instruction is carried through `LAT` stages, which lets synchronous DMEM load data catch up with it. Load data arriving during a stall is captured per entry. The stage applies load extension and result selection (pc+4, ALU, load, CSR) and drives registered register-file write outputs, plus a load-use hazard flag for decode.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `LAT`, 1: DMEM read latency in cycles; legal range 1..4.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: instruction presented this cycle.
- `in_pc` in XLEN: instruction PC.
- `in_alu` in XLEN: ALU result, which is also the load address.
- `in_inst` in 32: instruction word; rd = [11:7], funct3 = [14:12].
- `in_wbsel` in 2: 00 pc+4, 01 alu, 10 load, 11 csr.
- `in_regwen` in 1: instruction writes rd.
- `in_csr` in XLEN: CSR read value.
- `stall` in 1: freeze pipeline; no acceptance, no retirement.
- `dmem_rdata` in XLEN: aligned DMEM read word; valid exactly LAT cycles after the acceptance cycle of a load, independent of `stall`.
- `hz_rs1`, `hz_rs2` in 5: decode source registers.
- `hz_stall` out 1: an in-flight load targets nonzero `hz_rs1` or `hz_rs2`.
- `rf_we` out 1: registered write enable, one-cycle pulse per retired instruction.
- `rf_waddr` out 5: registered rd.
- `rf_wdata` out XLEN: registered write data.

## Operation
- Stages s1..sLAT. Each entry holds: valid, pc, alu, inst, wbsel, regwen, csr, age (3 bits), ldone, ldata.
- Acceptance: `in_valid & ~stall` at an edge loads s1 with age=1 and ldone=0. With `stall=0`, every stage shifts forward each edge. When s1 is not loaded, s1.valid=0.
- Stall: all stage fields are held except age and ldone/ldata. Stalled edges never accept.
- Age: every valid entry increments age each edge, saturating at LAT, stalled or not. Invariant: stage index ≤ age.
- Load capture: an entry is a load when wbsel=10. If it is valid, a load, ldone=0 and age==LAT in a cycle, `dmem_rdata` is stored into ldata at that edge and ldone is set. At most one entry qualifies per cycle.
- Retirement: sLAT valid and `stall=0`.
- Load source at retirement: ldone ? ldata : `dmem_rdata`.
- Load extension, with off = alu[log2(XLEN/8)-1:0] and w = source >> (8*off):
  - funct3 000 LB: sign-extend w[7:0].
  - funct3 100 LBU: zero-extend w[7:0].
  - funct3 001 LH: sign-extend w[15:0].
  - funct3 101 LHU: zero-extend w[15:0].
  - funct3 010 LW: sign-extend w[31:0] (plain w[31:0] at XLEN=32).
  - funct3 110 LWU: zero-extend w[31:0]; XLEN=64 only.
  - funct3 011 LD: w; XLEN=64 only.
  - Any other funct3: 0.
- Misaligned loads are undefined and are not checked.
- Result: wbsel 00 gives pc+4 modulo 2^XLEN; 01 gives alu; 10 gives the extended load; 11 gives csr.
- Output edge: `rf_we <= retire & regwen & (rd!=0)`. `rf_waddr <= rd` and `rf_wdata <= result` only when `rf_we` will be set; otherwise they hold.
- Hazard flag: `hz_stall` is combinational and asserted when any valid stage entry is a load with regwen, rd≠0, and rd equal to `hz_rs1` or `hz_rs2`.

## Timing
- Reset: at the edge with `reset=1`, all entry valid/ldone bits clear and `rf_we`/`rf_waddr`/`rf_wdata` go to 0. `hz_stall` is 0 from the following cycle.
- Reset mid-operation drops all in-flight instructions; DMEM data returning later is ignored.
- Reset has priority over stall and acceptance.
- Latency without stall: accepted at edge E0, `rf_we` high in the cycle after edge E_LAT. For LAT=1 that is the cycle after the next edge.
- Throughput: one instruction per cycle.
- Each retirement produces exactly one `rf_we` pulse.
- During stall, `rf_we` is 0 from the first stalled edge onward.
- Simultaneous events in one edge: acceptance, retirement and load capture all complete together.
- Age saturation: age never wraps past LAT.

## Test plan
- LAT=1: reset, then LW with rd=5 and alu=0x100; `dmem_rdata`=0xDEADBEEF in the following cycle -> next edge `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF for one cycle.
- Extension with `dmem_rdata`=0x80FF1234:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=2 -> 0x000080FF.
- LAT=3: LW rd=9 accepted, `stall`=1 for 5 cycles starting the next cycle, 0x12345678 presented only LAT cycles after acceptance -> after release, exactly one write of 0x12345678 to x9.
- wbsel=00, pc=0xFFFFFFFC, rd=1 -> `rf_wdata`=0x00000000. The same instruction with rd=0 -> `rf_we` stays 0. wbsel=11, csr=0xA5 -> `rf_wdata`=0xA5.
- LW rd=7 in s1 with `hz_rs2`=7 -> `hz_stall`=1; with rd=0 or a non-load -> `hz_stall`=0.
- `reset` pulsed while a load sits in s2 (LAT=3) -> no `rf_we` pulse afterwards and all outputs 0.

Source files
------------

// File: rtl/wb_pipe_if.sv
// Bus bundle between the writeback stage and its surroundings:
// instruction/result inputs, DMEM return data, hazard query and
// register-file write port.
interface wb_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_alu;
  logic [31:0]     in_inst;
  logic [1:0]      in_wbsel;
  logic            in_regwen;
  logic [XLEN-1:0] in_csr;
  logic            stall;
  logic [XLEN-1:0] dmem_rdata;
  logic [4:0]      hz_rs1;
  logic [4:0]      hz_rs2;
  logic            hz_stall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output in_valid, in_pc, in_alu, in_inst, in_wbsel, in_regwen, in_csr,
           stall, dmem_rdata, hz_rs1, hz_rs2,
    input  hz_stall, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_pc, in_alu, in_inst, in_wbsel, in_regwen, in_csr,
           stall, dmem_rdata, hz_rs1, hz_rs2,
    output hz_stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_pipe.sv
// Pipelined writeback stage. Instructions travel through LAT stages so
// that fixed-latency DMEM load data can catch up; the last stage selects
// and extends the result and drives a registered register-file write.
module wb_pipe #(
  parameter int XLEN = 32,
  parameter int LAT  = 1
) (
  input logic    clk,
  input logic    reset,
  wb_pipe_if.slave bus
);
  localparam int OFFW = $clog2(XLEN / 8);
  localparam logic [2:0] AGE_MAX = 3'(LAT);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      wbsel;
    logic            regwen;
    logic [XLEN-1:0] csr;
    logic [2:0]      age;
    logic            ldone;
    logic [XLEN-1:0] ldata;
  } entry_t;

  entry_t st  [LAT];
  entry_t upd [LAT];
  entry_t fresh;
  entry_t tail;

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] w;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] result;
  logic [OFFW-1:0] off;
  logic            we_nxt;
  logic            hz;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            unused_inst;

  // Only rd and funct3 of the instruction word matter here.
  assign unused_inst = ^{bus.in_inst[31:15], bus.in_inst[6:0]};

  // Build the s1 entry for an instruction presented this cycle.
  always_comb begin
    fresh        = '0;
    fresh.valid  = bus.in_valid;
    fresh.pc     = bus.in_pc;
    fresh.alu    = bus.in_alu;
    fresh.rd     = bus.in_inst[11:7];
    fresh.funct3 = bus.in_inst[14:12];
    fresh.wbsel  = bus.in_wbsel;
    fresh.regwen = bus.in_regwen;
    fresh.csr    = bus.in_csr;
    fresh.age    = 3'd1;
  end

  // Age every entry and capture DMEM data for the load whose data is due now.
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      upd[i] = st[i];
      if (st[i].valid) begin
        if (st[i].age < AGE_MAX) upd[i].age = st[i].age + 3'd1;
        if (st[i].wbsel == 2'b10 && !st[i].ldone && st[i].age == AGE_MAX) begin
          upd[i].ldone = 1'b1;
          upd[i].ldata = bus.dmem_rdata;
        end
      end
    end
  end

  // Select the load source, extend it and pick the final result.
  always_comb begin
    tail = st[LAT-1];
    src  = tail.ldone ? tail.ldata : bus.dmem_rdata;
    off  = tail.alu[OFFW-1:0];
    w    = src >> {off, 3'b000};
    ext  = '0;
    case (tail.funct3)
      3'b000: ext = XLEN'($signed(w[7:0]));
      3'b100: ext = XLEN'(w[7:0]);
      3'b001: ext = XLEN'($signed(w[15:0]));
      3'b101: ext = XLEN'(w[15:0]);
      3'b010: ext = XLEN'($signed(w[31:0]));
      3'b110: if (XLEN == 64) ext = XLEN'(w[31:0]);
      3'b011: if (XLEN == 64) ext = w;
      default: ext = '0;
    endcase
    case (tail.wbsel)
      2'b00:   result = tail.pc + XLEN'(4);
      2'b01:   result = tail.alu;
      2'b10:   result = ext;
      default: result = tail.csr;
    endcase
    we_nxt = tail.valid && !bus.stall && tail.regwen && (tail.rd != 5'd0);
  end

  // Flag decode when any in-flight load will write one of its sources.
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (st[i].valid && st[i].wbsel == 2'b10 && st[i].regwen && st[i].rd != 5'd0 &&
          (st[i].rd == bus.hz_rs1 || st[i].rd == bus.hz_rs2))
        hz = 1'b1;
    end
  end

  // Advance or hold the stages and register the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        st[i].valid <= 1'b0;
        st[i].ldone <= 1'b0;
      end
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (!bus.stall) begin
        st[0] <= fresh;
        for (int i = 1; i < LAT; i++) st[i] <= upd[i-1];
      end else begin
        for (int i = 0; i < LAT; i++) st[i] <= upd[i];
      end
      rf_we_q <= we_nxt;
      if (we_nxt) begin
        rf_waddr_q <= tail.rd;
        rf_wdata_q <= result;
      end
    end
  end

  assign bus.hz_stall = hz;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: one LAT=1 and one LAT=3 instance share the same
// stimulus; a countdown-queue model predicts each one's outputs.
module tb_wb_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] inst;
    logic [31:0] csr;
    logic [31:0] dmem;
    logic [1:0]  wbsel;
    logic        regwen;
    logic        stall;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  typedef struct {
    logic [31:0] pc, alu, csr, ldata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  wbsel;
    logic        regwen;
    int          moves_left;
    int          edges_to_data;
  } rec_t;

  stim_t cur;
  wb_pipe_if #(.XLEN(32)) bus1 ();
  wb_pipe_if #(.XLEN(32)) bus3 ();

  assign bus1.in_valid = cur.valid;   assign bus3.in_valid = cur.valid;
  assign bus1.in_pc = cur.pc;         assign bus3.in_pc = cur.pc;
  assign bus1.in_alu = cur.alu;       assign bus3.in_alu = cur.alu;
  assign bus1.in_inst = cur.inst;     assign bus3.in_inst = cur.inst;
  assign bus1.in_wbsel = cur.wbsel;   assign bus3.in_wbsel = cur.wbsel;
  assign bus1.in_regwen = cur.regwen; assign bus3.in_regwen = cur.regwen;
  assign bus1.in_csr = cur.csr;       assign bus3.in_csr = cur.csr;
  assign bus1.stall = cur.stall;      assign bus3.stall = cur.stall;
  assign bus1.dmem_rdata = cur.dmem;  assign bus3.dmem_rdata = cur.dmem;
  assign bus1.hz_rs1 = cur.rs1;       assign bus3.hz_rs1 = cur.rs1;
  assign bus1.hz_rs2 = cur.rs2;       assign bus3.hz_rs2 = cur.rs2;

  wb_pipe #(.XLEN(32), .LAT(1)) dut1 (.clk(clk), .reset(cur.rst), .bus(bus1.slave));
  wb_pipe #(.XLEN(32), .LAT(3)) dut3 (.clk(clk), .reset(cur.rst), .bus(bus3.slave));

  int n_cmp = 0;
  int n_fail = 0;

  rec_t        pend [2][8];
  int          pcnt [2];
  logic        exp_we [2];
  logic [4:0]  exp_waddr [2];
  logic [31:0] exp_wdata [2];
  bit          model_on = 0;
  int          lat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] src);
    logic [31:0] w;
    w = src >> (8 * off);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'h0, w[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input rec_t r);
    case (r.wbsel)
      2'b00:   return r.pc + 32'd4;
      2'b01:   return r.alu;
      2'b10:   return ref_load(r.f3, r.alu[1:0], r.ldata);
      default: return r.csr;
    endcase
  endfunction

  function automatic logic exp_hz(input int d, input logic [4:0] r1, input logic [4:0] r2);
    logic h = 1'b0;
    for (int k = 0; k < pcnt[d]; k++)
      if (pend[d][k].wbsel == 2'b10 && pend[d][k].regwen && pend[d][k].rd != 0 &&
          (pend[d][k].rd == r1 || pend[d][k].rd == r2))
        h = 1'b1;
    return h;
  endfunction

  // Reference model: each instruction retires after LAT unstalled edges;
  // its load data is whatever DMEM shows at the LAT-th edge after acceptance.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (cur.rst) begin
        pcnt[d] = 0;
        exp_we[d] = 1'b0;
        exp_waddr[d] = 5'd0;
        exp_wdata[d] = 32'd0;
        model_on = 1;
      end else begin
        exp_we[d] = 1'b0;
        for (int k = 0; k < pcnt[d]; k++) begin
          pend[d][k].edges_to_data--;
          if (pend[d][k].edges_to_data == 0) pend[d][k].ldata = cur.dmem;
        end
        if (!cur.stall) begin
          for (int k = 0; k < pcnt[d]; k++) pend[d][k].moves_left--;
          if (pcnt[d] > 0 && pend[d][0].moves_left == 0) begin
            if (pend[d][0].regwen && pend[d][0].rd != 0) begin
              exp_we[d] = 1'b1;
              exp_waddr[d] = pend[d][0].rd;
              exp_wdata[d] = ref_result(pend[d][0]);
            end
            for (int k = 0; k < pcnt[d] - 1; k++) pend[d][k] = pend[d][k+1];
            pcnt[d]--;
          end
          if (cur.valid) begin
            pend[d][pcnt[d]].pc = cur.pc;
            pend[d][pcnt[d]].alu = cur.alu;
            pend[d][pcnt[d]].csr = cur.csr;
            pend[d][pcnt[d]].ldata = 32'h0;
            pend[d][pcnt[d]].rd = cur.inst[11:7];
            pend[d][pcnt[d]].f3 = cur.inst[14:12];
            pend[d][pcnt[d]].wbsel = cur.wbsel;
            pend[d][pcnt[d]].regwen = cur.regwen;
            pend[d][pcnt[d]].moves_left = lat;
            pend[d][pcnt[d]].edges_to_data = lat;
            pcnt[d]++;
          end
        end
      end
    end
  end

  // Compare both instances against the model every cycle after reset.
  always begin
    @(posedge clk);
    #2;
    if (model_on) begin
      checkOutput("lat1 rf_we", {31'h0, bus1.rf_we}, {31'h0, exp_we[0]});
      checkOutput("lat1 rf_waddr", {27'h0, bus1.rf_waddr}, {27'h0, exp_waddr[0]});
      checkOutput("lat1 rf_wdata", bus1.rf_wdata, exp_wdata[0]);
      checkOutput("lat1 hz_stall", {31'h0, bus1.hz_stall}, {31'h0, exp_hz(0, cur.rs1, cur.rs2)});
      checkOutput("lat3 rf_we", {31'h0, bus3.rf_we}, {31'h0, exp_we[1]});
      checkOutput("lat3 rf_waddr", {27'h0, bus3.rf_waddr}, {27'h0, exp_waddr[1]});
      checkOutput("lat3 rf_wdata", bus3.rf_wdata, exp_wdata[1]);
      checkOutput("lat3 hz_stall", {31'h0, bus3.hz_stall}, {31'h0, exp_hz(1, cur.rs1, cur.rs2)});
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t mkInst(input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [1:0] wbsel, input logic [31:0] alu,
                                   input logic [31:0] dmem);
    stim_t s = '0;
    s.valid = 1'b1;
    s.inst = {17'h0, f3, rd, 7'b0000011};
    s.wbsel = wbsel;
    s.regwen = 1'b1;
    s.alu = alu;
    s.dmem = dmem;
    s.pc = 32'h0000_1000;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    cur = s;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Issue one instruction, idle with DMEM held, and tally writes on both instances.
  task automatic runInst(input string name, input stim_t s, input int exp_cnt,
                         input logic [4:0] exp_a, input logic [31:0] exp_d);
    int c1 = 0, c3 = 0;
    logic [4:0] a1 = 0, a3 = 0;
    logic [31:0] d1 = 0, d3 = 0;
    stim_t t;
    applyStimulus(s);
    for (int k = 0; k < 5; k++) begin
      t = idle();
      t.dmem = s.dmem;
      applyStimulus(t);
      settle();
      if (bus1.rf_we) begin c1++; a1 = bus1.rf_waddr; d1 = bus1.rf_wdata; end
      if (bus3.rf_we) begin c3++; a3 = bus3.rf_waddr; d3 = bus3.rf_wdata; end
    end
    checkOutput({name, " lat1 count"}, c1, exp_cnt);
    checkOutput({name, " lat3 count"}, c3, exp_cnt);
    if (exp_cnt > 0) begin
      checkOutput({name, " lat1 addr"}, {27'h0, a1}, {27'h0, exp_a});
      checkOutput({name, " lat1 data"}, d1, exp_d);
      checkOutput({name, " lat3 addr"}, {27'h0, a3}, {27'h0, exp_a});
      checkOutput({name, " lat3 data"}, d3, exp_d);
    end
  endtask

  initial begin
    stim_t s;
    int c3;
    logic [31:0] d3;
    logic [4:0] a3;
    logic [2:0] f3;
    logic [1:0] off;

    cur = idle();
    cur.rst = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(idle());
    settle();
    checkOutput("reset rf_we", {31'h0, bus1.rf_we}, 32'h0);
    checkOutput("reset rf_wdata", bus3.rf_wdata, 32'h0);

    // LAT=1 load: data the cycle after acceptance, write after the next edge.
    applyStimulus(mkInst(5'd5, 3'b010, 2'b10, 32'h100, 32'h0));
    s = idle(); s.dmem = 32'hDEADBEEF;
    applyStimulus(s);
    settle();
    checkOutput("lw lat1 we", {31'h0, bus1.rf_we}, 32'h1);
    checkOutput("lw lat1 waddr", {27'h0, bus1.rf_waddr}, 32'd5);
    checkOutput("lw lat1 wdata", bus1.rf_wdata, 32'hDEADBEEF);
    applyStimulus(idle());
    settle();
    checkOutput("lw lat1 pulse", {31'h0, bus1.rf_we}, 32'h0);
    repeat (4) begin applyStimulus(idle()); settle(); end

    // Load extension.
    runInst("lb",  mkInst(5'd3, 3'b000, 2'b10, 32'h203, 32'h80FF1234), 1, 5'd3, 32'hFFFFFF80);
    runInst("lbu", mkInst(5'd4, 3'b100, 2'b10, 32'h203, 32'h80FF1234), 1, 5'd4, 32'h00000080);
    runInst("lh",  mkInst(5'd6, 3'b001, 2'b10, 32'h202, 32'h80FF1234), 1, 5'd6, 32'hFFFF80FF);
    runInst("lhu", mkInst(5'd8, 3'b101, 2'b10, 32'h202, 32'h80FF1234), 1, 5'd8, 32'h000080FF);

    // pc+4 wraps, rd=0 never writes, CSR select.
    s = mkInst(5'd1, 3'b000, 2'b00, 32'h0, 32'h0); s.pc = 32'hFFFFFFFC;
    runInst("pc4 wrap", s, 1, 5'd1, 32'h0);
    s.inst[11:7] = 5'd0;
    runInst("rd0", s, 0, 5'd0, 32'h0);
    s = mkInst(5'd2, 3'b000, 2'b11, 32'h0, 32'h0); s.csr = 32'hA5;
    runInst("csr", s, 1, 5'd2, 32'hA5);

    // LAT=3 load stalled for 5 cycles; data shown only once, LAT cycles after acceptance.
    applyStimulus(mkInst(5'd9, 3'b010, 2'b10, 32'h300, 32'h0));
    c3 = 0; d3 = 0; a3 = 0;
    for (int k = 1; k <= 12; k++) begin
      s = idle();
      s.stall = (k <= 5);
      s.dmem = (k == 3) ? 32'h12345678 : 32'hBAD0BAD0;
      applyStimulus(s);
      settle();
      if (bus3.rf_we) begin c3++; d3 = bus3.rf_wdata; a3 = bus3.rf_waddr; end
    end
    checkOutput("stall lat3 count", c3, 32'd1);
    checkOutput("stall lat3 data", d3, 32'h12345678);
    checkOutput("stall lat3 addr", {27'h0, a3}, 32'd9);

    // Load-use hazard.
    s = mkInst(5'd7, 3'b010, 2'b10, 32'h400, 32'h0); s.rs2 = 5'd7;
    applyStimulus(s);
    s = idle(); s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("hz lw rd7 lat1", {31'h0, bus1.hz_stall}, 32'h1);
    checkOutput("hz lw rd7 lat3", {31'h0, bus3.hz_stall}, 32'h1);
    repeat (4) begin applyStimulus(s); settle(); end
    s = mkInst(5'd0, 3'b010, 2'b10, 32'h400, 32'h0); s.rs2 = 5'd0;
    applyStimulus(s);
    s = idle(); s.rs2 = 5'd0;
    applyStimulus(s);
    checkOutput("hz rd0 lat3", {31'h0, bus3.hz_stall}, 32'h0);
    s = mkInst(5'd7, 3'b010, 2'b01, 32'h400, 32'h0); s.rs2 = 5'd7;
    applyStimulus(s);
    s = idle(); s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("hz nonload lat3", {31'h0, bus3.hz_stall}, 32'h0);
    repeat (4) begin applyStimulus(idle()); settle(); end

    // Reset while a load sits in s2 of the LAT=3 instance.
    applyStimulus(mkInst(5'd12, 3'b010, 2'b10, 32'h500, 32'h0));
    applyStimulus(idle());
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    c3 = 0;
    for (int k = 0; k < 6; k++) begin
      s = idle(); s.dmem = 32'hCAFEF00D; s.rs1 = 5'd12;
      applyStimulus(s);
      settle();
      if (bus3.rf_we) c3++;
    end
    checkOutput("reset drop count", c3, 32'd0);
    checkOutput("reset drop waddr", {27'h0, bus3.rf_waddr}, 32'd0);
    checkOutput("reset drop wdata", bus3.rf_wdata, 32'd0);
    checkOutput("reset drop hz", {31'h0, bus3.hz_stall}, 32'd0);
    checkOutput("reset lat1 wdata", bus1.rf_wdata, 32'd0);

    // Randomised traffic with stalls and occasional resets.
    for (int n = 0; n < 600; n++) begin
      f3 = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      s = mkInst(5'($urandom_range(0, 7)), f3, 2'($urandom_range(0, 3)),
                 {$urandom(), 2'b00} | {30'h0, off}, $urandom());
      s.alu = {s.alu[31:2], off};
      s.valid = ($urandom_range(0, 3) != 0);
      s.regwen = ($urandom_range(0, 4) != 0);
      s.pc = {$urandom(), 2'b00} >> 0;
      s.pc[1:0] = 2'b00;
      s.csr = $urandom();
      s.stall = ($urandom_range(0, 3) == 0);
      s.rst = ($urandom_range(0, 59) == 0);
      s.rs1 = 5'($urandom_range(0, 7));
      s.rs2 = 5'($urandom_range(0, 7));
      applyStimulus(s);
    end
    applyStimulus(idle());
    repeat (6) begin applyStimulus(idle()); settle(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
